// File: rtl/tie_credit_out_port_if.sv
// FIFO-to-link handshake bundle for the credit-based output port.
// The master side is the port stage; the slave side is the FIFO/link environment.
interface tie_credit_out_port_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  credit_in;
  logic [DATA_WIDTH-1:0] link_flit;
  logic                  link_valid;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    input  credit_in,
    output fifo_rd_en,
    output link_flit,
    output link_valid
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    output credit_in,
    input  fifo_rd_en,
    input  link_flit,
    input  link_valid
  );

endinterface

// File: rtl/tie_credit_out_port.sv
// Drains a fall-through FIFO onto an inter-router link under credit flow control,
// tracking head/body/tail framing and raising sticky protocol error flags.
module tie_credit_out_port #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CREDIT_BITS = 4,
  parameter int unsigned MAX_CREDITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_on,
  tie_credit_out_port_if.master  port,
  output logic [CREDIT_BITS-1:0] o_credits,
  output logic                   o_pkt_active,
  output logic                   o_err_framing,
  output logic                   o_err_credit
);

  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_HEAD   = 2'b01;
  localparam logic [1:0] TYPE_TAIL   = 2'b10;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  localparam logic [CREDIT_BITS-1:0] CREDITS_MAX = CREDIT_BITS'(MAX_CREDITS);
  localparam logic [CREDIT_BITS-1:0] CREDITS_ONE = CREDIT_BITS'(1);

  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } state_e;

  state_e                  r_state;
  state_e                  w_state_next;
  logic [CREDIT_BITS-1:0]  r_credits;
  logic [CREDIT_BITS-1:0]  w_credits_next;
  logic [DATA_WIDTH-1:0]   r_link_flit;
  logic                    r_link_valid;
  logic                    r_err_framing;
  logic                    r_err_credit;

  logic                    w_pop;
  logic [1:0]              w_type;
  logic                    w_frame_err;
  logic                    w_credit_overflow;

  // Reset is folded in so the FIFO never sees a pop while the port is held.
  assign w_pop  = ~reset & i_on & ~port.fifo_empty & (r_credits != '0);
  assign w_type = port.fifo_data[DATA_WIDTH-1 -: 2];

  // Framing FSM: advances only on a pop, keyed by the type of the popped flit.
  always_comb begin
    w_state_next = r_state;
    w_frame_err  = 1'b0;
    if (w_pop) begin
      unique case (r_state)
        StIdle: begin
          case (w_type)
            TYPE_HEAD:   w_state_next = StInPkt;
            TYPE_SINGLE: w_state_next = StIdle;
            default:     w_frame_err  = 1'b1;
          endcase
        end
        StInPkt: begin
          case (w_type)
            TYPE_BODY:   w_state_next = StInPkt;
            TYPE_TAIL:   w_state_next = StIdle;
            TYPE_HEAD:   w_frame_err  = 1'b1;
            default: begin
              w_state_next = StIdle;
              w_frame_err  = 1'b1;
            end
          endcase
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // A simultaneous pop and credit return cancel out.
  always_comb begin
    w_credits_next    = r_credits;
    w_credit_overflow = 1'b0;
    if (w_pop && !port.credit_in) begin
      w_credits_next = r_credits - CREDITS_ONE;
    end else if (!w_pop && port.credit_in) begin
      if (r_credits == CREDITS_MAX) begin
        w_credit_overflow = 1'b1;
      end else begin
        w_credits_next = r_credits + CREDITS_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_credits     <= CREDITS_MAX;
      r_link_flit   <= '0;
      r_link_valid  <= 1'b0;
      r_err_framing <= 1'b0;
      r_err_credit  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_credits    <= w_credits_next;
      r_link_valid <= w_pop;
      if (w_pop) begin
        r_link_flit <= port.fifo_data;
      end
      if (w_frame_err) begin
        r_err_framing <= 1'b1;
      end
      if (w_credit_overflow) begin
        r_err_credit <= 1'b1;
      end
    end
  end

  assign port.fifo_rd_en = w_pop;
  assign port.link_flit  = r_link_flit;
  assign port.link_valid = r_link_valid;
  assign o_credits       = r_credits;
  assign o_pkt_active    = (r_state == StInPkt);
  assign o_err_framing   = r_err_framing;
  assign o_err_credit    = r_err_credit;

endmodule
